// File: rtl/ddfs_pkg.sv
// Shared definitions for the DDFS phase path: default widths, dither LFSR
// constants and small helpers used by the accumulator and the LFSR.
package ddfs_pkg;

  localparam int PHASE_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF  = 11;

  // 16-bit Galois LFSR, right-shifting form
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef logic [PHASE_WIDTH_DEF-1:0] phase_t;

  // One Galois step: shift right, fold the polynomial back in when a 1 falls out
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_POLY) : (state >> 1);
  endfunction

  // Number of dither bits that fit below the address field (capped at the LFSR width)
  function automatic int dither_width(input int phase_w, input int addr_w);
    return ((phase_w - addr_w) < 16) ? (phase_w - addr_w) : 16;
  endfunction

endpackage

// File: rtl/ddfs_lfsr.sv
// Dither source for the phase truncation. Only built when DDFS_PHASE_DITHER_EN
// is defined; the undithered build has no LFSR at all.
`ifdef DDFS_PHASE_DITHER_EN
module ddfs_lfsr
  import ddfs_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_reseed,
  output logic [15:0] o_state
);

  // Reseed wins over advance so a phase clear always restarts the same dither sequence
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_state <= LFSR_SEED;
    end else if (i_reseed) begin
      o_state <= LFSR_SEED;
    end else if (i_enable) begin
      o_state <= lfsr_step(o_state);
    end
  end

endmodule
`endif

// File: rtl/ddfs_phase_acc.sv
// DDFS phase accumulator and sine-ROM address generator.
// Optional truncation dither: define DDFS_PHASE_DITHER_EN.
//
// Pipeline for a tick sampled at edge k:
//   k   : acc += ftw_active (FTW in force before any commit on this edge)
//   k+1 : o_r_addr = top bits of (acc + offset_active [+ dither]), o_addr_valid, o_wrap
//   k+2 : o_data_valid, lined up with the synchronous ROM output
module ddfs_phase_acc
  import ddfs_pkg::*;
#(
  parameter int PHASE_WIDTH    = PHASE_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int COMMIT_ON_WRAP = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tick,
  input  logic                   i_clear,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [PHASE_WIDTH-1:0] i_ftw,
  input  logic [PHASE_WIDTH-1:0] i_offset,
  output logic [ADDR_WIDTH-1:0]  o_r_addr,
  output logic                   o_addr_valid,
  output logic                   o_data_valid,
  output logic                   o_wrap
);

  if (ADDR_WIDTH > PHASE_WIDTH) begin : g_bad_widths
    $error("ddfs_phase_acc: ADDR_WIDTH must not exceed PHASE_WIDTH");
  end

  logic [PHASE_WIDTH-1:0] acc;
  logic [PHASE_WIDTH-1:0] ftw_active;
  logic [PHASE_WIDTH-1:0] offset_active;
  logic [PHASE_WIDTH-1:0] shadow_ftw;
  logic [PHASE_WIDTH-1:0] shadow_offset;
  logic                   pending;
  logic                   cfg_ready_q;

  logic                   s1_valid;
  logic                   s1_carry;

  logic [PHASE_WIDTH:0]   acc_sum;
  logic                   carry;
  logic                   cfg_write;
  logic                   commit;
  logic                   pending_next;
  logic [PHASE_WIDTH-1:0] dither;
  logic [PHASE_WIDTH-1:0] phase;
  logic [ADDR_WIDTH-1:0]  addr_next;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_active};
  assign carry     = acc_sum[PHASE_WIDTH];

  // Write needs an empty shadow and commit needs a full one, so they never collide
  assign cfg_write = i_cfg_valid && cfg_ready_q;
  assign commit    = pending &&
                     (i_clear || (i_tick && ((COMMIT_ON_WRAP == 0) || carry)));

  // Next value of the pending flag, shared by the flag and the registered ready
  always_comb begin
    pending_next = pending;
    if (cfg_write) begin
      pending_next = 1'b1;
    end else if (commit) begin
      pending_next = 1'b0;
    end
  end

`ifdef DDFS_PHASE_DITHER_EN
  localparam int DITHER_W = dither_width(PHASE_WIDTH, ADDR_WIDTH);
  localparam logic [15:0] DITHER_MASK = 16'((32'd1 << DITHER_W) - 32'd1);

  logic [15:0] lfsr_state;

  ddfs_lfsr u_lfsr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_tick),
    .i_reseed (i_clear),
    .o_state  (lfsr_state)
  );

  // Dither stays strictly below the address LSB, so it can move the address by at most one
  assign dither = PHASE_WIDTH'(lfsr_state & DITHER_MASK);
`else
  assign dither = '0;
`endif

  assign phase     = acc + offset_active + dither;
  assign addr_next = ADDR_WIDTH'(phase >> (PHASE_WIDTH - ADDR_WIDTH));

  // Shadow capture on handshake, transfer to the active set on commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_ftw    <= '0;
      shadow_offset <= '0;
      ftw_active    <= '0;
      offset_active <= '0;
      pending       <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      if (cfg_write) begin
        shadow_ftw    <= i_ftw;
        shadow_offset <= i_offset;
      end
      if (commit) begin
        ftw_active    <= shadow_ftw;
        offset_active <= shadow_offset;
      end
      pending     <= pending_next;
      cfg_ready_q <= !pending_next;
    end
  end

  assign o_cfg_ready = cfg_ready_q;

  // Phase accumulator; clear beats tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
    end else if (i_clear) begin
      acc <= '0;
    end else if (i_tick) begin
      acc <= acc_sum[PHASE_WIDTH-1:0];
    end
  end

  // Remember that the accumulator just advanced, and whether that add carried out
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_carry <= 1'b0;
    end else begin
      s1_valid <= i_tick && !i_clear;
      s1_carry <= i_tick && !i_clear && carry;
    end
  end

  // Address stage and ROM-latency strobe; a clear flushes strobes but keeps the last address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_r_addr     <= '0;
      o_addr_valid <= 1'b0;
      o_data_valid <= 1'b0;
      o_wrap       <= 1'b0;
    end else if (i_clear) begin
      o_addr_valid <= 1'b0;
      o_data_valid <= 1'b0;
      o_wrap       <= 1'b0;
    end else begin
      if (s1_valid) begin
        o_r_addr <= addr_next;
      end
      o_addr_valid <= s1_valid;
      o_wrap       <= s1_valid && s1_carry;
      o_data_valid <= o_addr_valid;
    end
  end

endmodule
